// File: rtl/serial_sub4b_pkg.sv
// Shared state encodings and parameter limits for the bit-serial subtractor.
package serial_sub4b_pkg;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_sub4b_full_sub1b.sv
// One-bit full subtractor: d = a - b - bin, with borrow-out.
module full_sub1b (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_sub4b.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH cycles, LSB first,
// through a single full-subtractor cell and a registered borrow.
module serial_sub4b
    import serial_sub4b_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             bout_q, bout_d;
    logic             ovf_q, ovf_d;

    logic cell_d, cell_bout;
    logic accept, last_bit;

    full_sub1b u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (brw_q),
        .d    (cell_d),
        .bout (cell_bout)
    );

    // DONE can accept a new request directly, giving back-to-back throughput.
    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            diff_q  <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            diff_q  <= diff_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = ST_IDLE;
        unique case (state_q)
            ST_IDLE:  state_d = start ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: state_d = last_bit ? ST_DONE : ST_SHIFT;
            ST_DONE:  state_d = start ? ST_SHIFT : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state; visible results only move on the final bit.
    always_comb begin
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        diff_d  = diff_q;
        cnt_d   = cnt_q;
        brw_d   = brw_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        if (accept) begin
            a_sh_d  = a;
            b_sh_d  = b;
            res_d   = '0;
            cnt_d   = '0;
            brw_d   = bin;
            a_msb_d = a[WIDTH-1];
            b_msb_d = b[WIDTH-1];
        end else if (state_q == ST_SHIFT) begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            res_d  = {cell_d, res_q[WIDTH-1:1]};
            brw_d  = cell_bout;
            cnt_d  = cnt_q + CW'(1);
            if (last_bit) begin
                // On the last bit the cell output is the result MSB.
                diff_d = {cell_d, res_q[WIDTH-1:1]};
                bout_d = cell_bout;
                ovf_d  = (a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_d);
            end
        end
    end

    always_comb begin
        busy = (state_q == ST_SHIFT);
        done = (state_q == ST_DONE);
        diff = diff_q;
        bout = bout_q;
        ovf  = ovf_q;
    end

endmodule

// File: tb/tb_serial_sub4b.sv
// Scoreboard bench for serial_sub4b (WIDTH=4): stimulus pushes expected
// results, a monitor pops and compares on every done pulse.
module tb_serial_sub4b;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a, b;
    logic       bin;
    logic       busy, done, bout, ovf;
    logic [3:0] diff;

    typedef struct {
        logic [3:0] d;
        logic       bo;
        logic       ov;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         busy_cnt = 0;
    logic [3:0] held_diff = 4'h0;

    serial_sub4b #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    always begin
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
        if (rst) begin
            held_diff = 4'h0;
        end else if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", int'(diff), int'(e.d));
                chk("bout", int'(bout), int'(e.bo));
                chk("ovf", int'(ovf), int'(e.ov));
                chk("done_cycle", cyc, e.cyc);
                held_diff = e.d;
            end
        end else if (diff !== held_diff) begin
            chk("diff_hold", int'(diff), int'(held_diff));
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            chk("drain_timeout", q.size(), 0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Single pulsed operation; done expected 5 edges after the pulse is driven.
    task automatic op(input logic [3:0] ta, input logic [3:0] tb2, input logic tbin,
                      input logic [3:0] ed, input logic eb, input logic eo);
        exp_t e;
        @(negedge clk);
        a = ta; b = tb2; bin = tbin; start = 1'b1;
        e.d = ed; e.bo = eb; e.ov = eo; e.cyc = cyc + 5;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a = ~ta; b = ~tb2; bin = ~tbin;
        wait_drain();
    endtask

    initial begin
        exp_t e;
        rst = 1'b1; start = 1'b0; a = 4'h0; b = 4'h0; bin = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_diff", int'(diff), 0);
        rst = 1'b0;
        @(negedge clk);

        busy_cnt = 0;
        op(4'h2, 4'h1, 1'b0, 4'h1, 1'b0, 1'b0);
        chk("busy_cycles", busy_cnt, 4);
        op(4'h0, 4'h1, 1'b0, 4'hF, 1'b1, 1'b0);
        op(4'h5, 4'hA, 1'b1, 4'hA, 1'b1, 1'b1);

        // Reset in the third cycle of an operation: everything clears, no done.
        @(negedge clk);
        a = 4'h9; b = 4'h2; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_diff", int'(diff), 0);
        chk("midrst_bout", int'(bout), 0);
        chk("midrst_ovf", int'(ovf), 0);
        rst = 1'b0;
        repeat (8) @(negedge clk);

        op(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);

        // Start while busy is ignored and operand changes have no effect.
        @(negedge clk);
        a = 4'h7; b = 4'h3; bin = 1'b0; start = 1'b1;
        e.d = 4'h4; e.bo = 1'b0; e.ov = 1'b0; e.cyc = cyc + 5;
        q.push_back(e);
        @(negedge clk);
        start = 1'b0; a = 4'hC; b = 4'h5;
        @(negedge clk);
        a = 4'h0; b = 4'h1; bin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 4'hE;
        wait_drain();
        repeat (4) @(negedge clk);

        // Start held high: two back-to-back operations, done pulses 5 apart.
        @(negedge clk);
        a = 4'h9; b = 4'h3; bin = 1'b0; start = 1'b1;
        e.d = 4'h6; e.bo = 1'b0; e.ov = 1'b1; e.cyc = cyc + 5;
        q.push_back(e);
        e.d = 4'hE; e.bo = 1'b1; e.ov = 1'b0; e.cyc = cyc + 10;
        q.push_back(e);
        @(negedge clk);
        a = 4'h3; b = 4'h5;
        repeat (5) @(negedge clk);
        start = 1'b0;
        wait_drain();
        repeat (6) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout actual=%0d expected=done", cyc);
        $fatal(1);
    end

endmodule
